// File: rtl/alu_red_pkg.sv
// Shared definitions for the ALU byte-reduction unit: data word and lane
// types, the widths of the intermediate sums, and where each flag sits in
// the packed flag vector.
package alu_red_pkg;

  typedef logic [15:0] word_t;
  typedef logic [7:0]  lane_t;

  // A lane sum needs one extra bit, and the sum of two lane sums one more.
  typedef logic [8:0]  lane_sum_t;
  typedef logic [9:0]  red_sum_t;

  // The result plus one carry bit above bit 15, used for the overflow term.
  typedef logic [16:0] word_carry_t;

  localparam int FLAG_W = 3;
  localparam int SIGN   = 2;
  localparam int ZERO   = 1;
  localparam int OVFL   = 0;

  typedef logic [FLAG_W-1:0] flags_t;

  // Packs the three flags so their bit positions always agree with the
  // SIGN/ZERO/OVFL indices that the branch logic uses.
  function automatic flags_t packFlags(input logic signFlag,
                                       input logic zeroFlag,
                                       input logic ovflFlag);
    flags_t packed_v;
    packed_v       = '0;
    packed_v[SIGN] = signFlag;
    packed_v[ZERO] = zeroFlag;
    packed_v[OVFL] = ovflFlag;
    return packed_v;
  endfunction

endpackage

// File: rtl/alu_red_lane_adder.sv
// Adds two unsigned 8-bit lanes into a 9-bit sum so that the carry out of
// the lane is kept instead of being truncated.
module red_lane_adder
  import alu_red_pkg::*;
(
  input  lane_t     lhs,
  input  lane_t     rhs,
  output lane_sum_t sum
);

  // Both operands are zero-extended before the add so the carry lands in
  // bit 8 of the sum.
  assign sum = {1'b0, lhs} + {1'b0, rhs};

endmodule

// File: rtl/alu_red.sv
// Byte-reduction unit of the ALU: sums the four bytes of operands a and b,
// produces the zero-extended result with N/Z/V flags combinationally, and
// keeps a registered copy of the flags for later branch evaluation.
module alu_red
  import alu_red_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic [15:0]   a,
  input  logic [15:0]   b,
  input  logic          flag_wr,
  output logic [15:0]   result,
  output logic          ovfl,
  output logic          zero,
  output logic          sign,
  output logic [2:0]    flags_q
);

  lane_sum_t   aLaneSum;
  lane_sum_t   bLaneSum;
  red_sum_t    totalSum;
  word_carry_t wideResult;
  flags_t      flagsNow;
  flags_t      flags_d;

  red_lane_adder uAddA (
    .lhs (a[15:8]),
    .rhs (a[7:0]),
    .sum (aLaneSum)
  );

  red_lane_adder uAddB (
    .lhs (b[15:8]),
    .rhs (b[7:0]),
    .sum (bLaneSum)
  );

  // The two 9-bit lane sums are widened to 10 bits before combining, so the
  // full 0..1020 range survives.
  assign totalSum = {1'b0, aLaneSum} + {1'b0, bLaneSum};

  // The result is carried one bit past the 16-bit word; that extra bit is
  // the overflow term and is structurally zero because the sum fits in 10.
  assign wideResult = {7'b0, totalSum};
  assign result     = wideResult[15:0];
  assign ovfl       = wideResult[16];

  // Sign comes from the top result bit rather than a constant so it stays
  // correct if the datapath ever widens.
  assign sign = result[15];
  assign zero = (result == 16'h0000);

  assign flagsNow = packFlags(sign, zero, ovfl);

  // Capture the live flags only when the execute stage asks for it,
  // otherwise hold the last captured value.
  always_comb begin
    flags_d = flags_q;
    if (flag_wr) begin
      flags_d = flagsNow;
    end
  end

  // Flag register with asynchronous clear; the combinational outputs do
  // not depend on reset at all.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
    end else begin
      flags_q <= flags_d;
    end
  end

endmodule

// File: tb/tb_alu_red.sv
// Directed and random checks of the ALU byte-reduction unit and its flag
// register.
module tb_alu_red;

   logic        clk;
   logic        rst_n;
   logic [15:0] a;
   logic [15:0] b;
   logic        flag_wr;
   logic [15:0] result;
   logic        ovfl;
   logic        zero;
   logic        sign;
   logic [2:0]  flags_q;

   int errors;
   int checks;

   alu_red dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .a       (a),
      .b       (b),
      .flag_wr (flag_wr),
      .result  (result),
      .ovfl    (ovfl),
      .zero    (zero),
      .sign    (sign),
      .flags_q (flags_q)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drives operands and lets the combinational datapath settle.
   task automatic applyStimulus(input logic [15:0] aVal, input logic [15:0] bVal);
      a = aVal;
      b = bVal;
      #1;
   endtask

   // One comparison: counts it and reports any difference.
   task automatic checkOutput(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%04h expected=0x%04h", tag, observed, expected);
      end
   endtask

   // Checks the four combinational outputs against a hand-computed sum.
   task automatic checkComb(input string tag, input logic [15:0] expSum);
      checkOutput({tag, ".result"}, result, expSum);
      checkOutput({tag, ".zero"}, {15'b0, zero}, {15'b0, (expSum == 16'h0000)});
      checkOutput({tag, ".sign"}, {15'b0, sign}, 16'h0000);
      checkOutput({tag, ".ovfl"}, {15'b0, ovfl}, 16'h0000);
   endtask

   // Waits for the next rising edge and samples just after it.
   task automatic clockStep();
      @(posedge clk);
      #1;
   endtask

   // Linear directed sequence followed by a random sweep.
   initial begin
      logic [15:0] ra;
      logic [15:0] rb;
      logic [15:0] expSum;
      errors  = 0;
      checks  = 0;
      rst_n   = 1'b1;
      flag_wr = 1'b0;
      a       = 16'h0000;
      b       = 16'h0000;

      // Reset asserted before any clock edge: flags must clear immediately.
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("reset.flags_q", {13'b0, flags_q}, 16'h0000);

      // Combinational datapath works while reset is held.
      applyStimulus(16'h0000, 16'h0000);
      checkComb("zeros", 16'd0);
      applyStimulus(16'hFFFF, 16'hFFFF);
      checkComb("ones", 16'd1020);
      applyStimulus(16'h0102, 16'h0304);
      checkComb("small", 16'd10);
      applyStimulus(16'h80FF, 16'h0001);
      checkComb("lanecarry", 16'd384);
      applyStimulus(16'h00FF, 16'hFF00);
      checkComb("mixed", 16'd510);

      // Reset still held across an edge with flag_wr high.
      flag_wr = 1'b1;
      applyStimulus(16'h0000, 16'h0000);
      clockStep();
      checkOutput("reset.held", {13'b0, flags_q}, 16'h0000);

      // Release reset away from an edge, then capture the zero flag.
      rst_n = 1'b1;
      clockStep();
      checkOutput("capture.zero", {13'b0, flags_q}, 16'h0002);

      // Hold: flag_wr low keeps the captured flags.
      flag_wr = 1'b0;
      applyStimulus(16'h0001, 16'h0000);
      clockStep();
      checkOutput("hold", {13'b0, flags_q}, 16'h0002);
      clockStep();
      checkOutput("hold2", {13'b0, flags_q}, 16'h0002);

      // Capture of a nonzero result clears the zero flag.
      flag_wr = 1'b1;
      clockStep();
      checkOutput("capture.nonzero", {13'b0, flags_q}, 16'h0000);

      // Recapture zero, then assert reset mid-cycle.
      applyStimulus(16'h0000, 16'h0000);
      clockStep();
      checkOutput("recapture.zero", {13'b0, flags_q}, 16'h0002);
      flag_wr = 1'b0;
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("async.reset", {13'b0, flags_q}, 16'h0000);
      checkComb("duringreset", 16'd0);

      // Reset released mid-operation resumes on the first edge with flag_wr.
      rst_n = 1'b1;
      clockStep();
      checkOutput("resume.nowr", {13'b0, flags_q}, 16'h0000);
      flag_wr = 1'b1;
      clockStep();
      checkOutput("resume.wr", {13'b0, flags_q}, 16'h0002);
      flag_wr = 1'b0;

      // Random sweep against a bench-side sum of the four bytes.
      for (int i = 0; i < 100; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         expSum = 16'(ra[15:8]) + 16'(ra[7:0]) + 16'(rb[15:8]) + 16'(rb[7:0]);
         applyStimulus(ra, rb);
         checkComb("rand", expSum);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Overall time bound so the run always ends.
   initial begin
      #100000;
      $display("[TB] FAIL timeout observed=running expected=finished");
      $fatal(1, "[TB] timeout");
   end

endmodule
